lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of REQ-state cycles waited for dmem_ack before an error is raised.
REQ-002 Ports SHALL be as follows.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_rden  in  1  load request from control decode.
- mem_wren  in  1  store request from control decode.
- l_sel  in  3  load type: 001 LB, 010 LH, 011 LBU, 100 LHU, 101 LW.
- s_sel  in  2  store type: 01 SB, 10 SH, 11 SW.
- addr  in  32  byte address from ALU.
- wdata  in  32  store data (rs2).
- dmem_req  out  1  memory request, held until ack or timeout.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  32  word address, {addr[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  memory completion, one-cycle pulse.
- dmem_rdata  in  32  read word, valid with dmem_ack.
- stall  out  1  freeze PC/fetch while access is in flight.
- ld_data  out  32  aligned, extended load result.
- ld_valid  out  1  ld_data valid (one cycle).
- err  out  1  misaligned, illegal-select or timeout (one cycle).

Function
REQ-003 FSM SHALL have states IDLE, REQ, DONE, ERR.
REQ-004 IDLE with mem_rden or mem_wren high SHALL capture addr, wdata, l_sel, s_sel and direction into registers; mem_wren SHALL win if both are high.
REQ-005 Captured request SHALL go to ERR if misaligned (halfword with addr[0]=1; word with addr[1:0]!=0) or select illegal (l_sel 000/110/111 on load, s_sel 00 on store); otherwise to REQ.
REQ-006 stall SHALL be 1 in IDLE when a request is present, and in REQ; 0 in DONE, ERR, and idle IDLE.
REQ-007 REQ SHALL drive dmem_req=1 with dmem_we, dmem_addr, dmem_be, dmem_wdata from registered values, stable until exit.
REQ-008 dmem_be: byte = 0001<<addr[1:0]; half = 0011<<{addr[1],1'b0}; word = 1111; loads use same mask.
REQ-009 dmem_wdata: SB replicates wdata[7:0] to 4 lanes, SH replicates wdata[15:0] to 2 lanes, SW passes wdata.
REQ-010 REQ with dmem_ack=1 SHALL go to DONE; loads register dmem_rdata shifted right by 8*addr[1:0], sign-extended (LB, LH) or zero-extended (LBU, LHU) to ld_data.
REQ-011 A cycle counter SHALL clear on REQ entry, increment each REQ cycle without ack, and go to ERR when it reaches TIMEOUT-1 without ack; ack in that same cycle SHALL take priority (DONE).
REQ-012 DONE SHALL assert ld_valid=1 for loads only, last one cycle, and return to IDLE; requests SHALL NOT be accepted in DONE (inputs still show the completed instruction).
REQ-013 ERR SHALL assert err=1 for one cycle, dmem_req=0, and return to IDLE; no request accepted in ERR.
REQ-014 dmem_ack outside REQ SHALL be ignored.
REQ-015 ld_data SHALL hold its value until the next load completion.
REQ-016 Minimum latency: accept cycle + 1 REQ cycle + DONE = stall high for 2 cycles.

Reset
REQ-017 rst_n low SHALL immediately force IDLE, clear the counter and captured registers, and drive every output to 0, including mid-REQ (dmem_req drops without waiting for ack).
REQ-018 After rst_n deasserts, the first rising edge with a request SHALL be accepted normally.

Verification
REQ-019 LW addr=0x100, ack on 1st REQ cycle, rdata=0xDEADBEEF -> stall 2 cycles, dmem_be=1111, ld_data=0xDEADBEEF, ld_valid 1 cycle.
REQ-020 LB addr=0x103, rdata=0x80FF_0000 -> dmem_be=1000, ld_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-021 SH addr=0x22, wdata=0x1234ABCD -> dmem_we=1, dmem_addr=0x20, dmem_be=1100, dmem_wdata=0xABCDABCD, ld_valid stays 0.
REQ-022 LW addr=0x102 -> no dmem_req, err 1 cycle, return IDLE; l_sel=110 load -> same.
REQ-023 TIMEOUT=16, ack never -> dmem_req high 16 cycles, err pulse, dmem_req low; late ack ignored.
REQ-024 rst_n low during REQ -> dmem_req and stall 0 asynchronously; next LW after release completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller; aligns byte/half/word accesses, drives a
// req/ack data-memory port with timeout, and extends load results.
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rden,
  input  logic        mem_wren,
  input  logic [2:0]  l_sel,
  input  logic [1:0]  s_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] addr_r, wdata_r, sh, ext;
  logic [2:0] lsel_r;
  logic [1:0] ssel_r, sz_in, sz_r;
  logic we_r, start, bad;
  // access size code: 0 byte, 1 half, 2 word, 3 illegal select
  function automatic logic [1:0] size(input logic we, input logic [2:0] ls, input logic [1:0] ss);
    if (we) return ss == 2'd0 ? 2'd3 : ss - 2'd1;
    return (ls == 3'd1 || ls == 3'd3) ? 2'd0 :
           (ls == 3'd2 || ls == 3'd4) ? 2'd1 : ls == 3'd5 ? 2'd2 : 2'd3;
  endfunction
  assign start = state == IDLE && (mem_rden || mem_wren);
  assign sz_in = size(mem_wren, l_sel, s_sel);
  assign bad   = sz_in == 2'd3 || (sz_in == 2'd1 && addr[0]) || (sz_in == 2'd2 && addr[1:0] != 2'd0);
  assign sz_r  = size(we_r, lsel_r, ssel_r);
  assign sh    = dmem_rdata >> {addr_r[1:0], 3'b000};
  assign ext   = lsel_r == 3'd1 ? {{24{sh[7]}}, sh[7:0]} :
                 lsel_r == 3'd2 ? {{16{sh[15]}}, sh[15:0]} :
                 lsel_r == 3'd3 ? {24'd0, sh[7:0]} :
                 lsel_r == 3'd4 ? {16'd0, sh[15:0]} : sh;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      lsel_r  <= '0;
      ssel_r  <= '0;
      we_r    <= 1'b0;
      ld_data <= '0;
    end else begin
      if (start) begin
        addr_r  <= addr;
        wdata_r <= wdata;
        lsel_r  <= l_sel;
        ssel_r  <= s_sel;
        we_r    <= mem_wren;
      end
      cnt <= state == REQ ? cnt + 1'b1 : '0;
      if (state == REQ && dmem_ack && !we_r) ld_data <= ext;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = bad ? ERR : REQ;
      REQ:     state_nx = dmem_ack ? DONE : cnt == CW'(TIMEOUT - 1) ? ERR : REQ;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    dmem_req   = state == REQ;
    dmem_we    = dmem_req && we_r;
    dmem_addr  = dmem_req ? {addr_r[31:2], 2'b00} : '0;
    dmem_be    = !dmem_req ? 4'd0 : sz_r == 2'd0 ? 4'b0001 << addr_r[1:0] :
                 sz_r == 2'd1 ? 4'b0011 << {addr_r[1], 1'b0} : 4'b1111;
    dmem_wdata = !dmem_req ? '0 : sz_r == 2'd0 ? {4{wdata_r[7:0]}} :
                 sz_r == 2'd1 ? {2{wdata_r[15:0]}} : wdata_r;
    stall      = rst_n && (start || dmem_req);
    ld_valid   = state == DONE && !we_r;
    err        = state == ERR;
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized and directed checks of lsu_ctrl against a
// byte-lane arithmetic model of the load/store rules.
module tb_lsu_ctrl;
  logic clk = 0, rst_n = 0;
  logic mem_rden = 0, mem_wren = 0, dmem_ack = 0;
  logic [2:0] l_sel = 0;
  logic [1:0] s_sel = 0;
  logic [31:0] addr = 0, wdata = 0, dmem_rdata = 0;
  logic dmem_req, dmem_we, stall, ld_valid, err;
  logic [31:0] dmem_addr, dmem_wdata, ld_data;
  logic [3:0] dmem_be;
  int tests = 0, fails = 0;
  logic [31:0] last_ld = 0;

  lsu_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .l_sel(l_sel), .s_sel(s_sel), .addr(addr), .wdata(wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .ld_data(ld_data),
    .ld_valid(ld_valid), .err(err)
  );

  always #5 clk = ~clk;

  // access width in bytes, 0 when the select code is illegal
  function automatic int nbytes(bit st, logic [2:0] ls, logic [1:0] ss);
    if (st) return ss == 1 ? 1 : ss == 2 ? 2 : ss == 3 ? 4 : 0;
    if (ls == 1 || ls == 3) return 1;
    if (ls == 2 || ls == 4) return 2;
    if (ls == 5) return 4;
    return 0;
  endfunction

  task automatic access(input bit st, input logic [2:0] ls, input logic [1:0] ss,
                        input logic [31:0] a, input logic [31:0] w, input logic [31:0] rd,
                        input int delay, input string name);
    int nb, off, reqc, stallc, errc, vldc, n, exp_req, exp_err;
    bit fin;
    logic [31:0] exp_be32, exp_wd, exp_ld, got_ld, mask;
    nb = nbytes(st, ls, ss);
    off = int'(a[1:0]);
    exp_err = (nb == 0 || off % nb != 0) ? 1 : 0;
    exp_req = exp_err ? 0 : (delay >= 16 ? 16 : delay + 1);
    if (!exp_err && delay >= 16) exp_err = 1;
    exp_be32 = ((32'd1 << nb) - 1) << off;
    exp_wd = nb == 1 ? {4{w[7:0]}} : nb == 2 ? {2{w[15:0]}} : w;
    mask = nb == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 1;
    exp_ld = (rd >> (8 * off)) & mask;
    if ((ls == 1 || ls == 2) && nb != 4 && exp_ld[8 * nb - 1]) exp_ld = exp_ld | ~mask;
    @(negedge clk);
    mem_rden = !st; mem_wren = st; l_sel = ls; s_sel = ss; addr = a; wdata = w; dmem_rdata = rd;
    #1;
    reqc = 0; stallc = 0; errc = 0; vldc = 0; n = 0; fin = 0; got_ld = 'x;
    while (!fin && n < 60) begin
      if (dmem_req) begin
        tests++;
        if (dmem_we !== st || dmem_addr !== {a[31:2], 2'b00} || dmem_be !== exp_be32[3:0] ||
            (st && dmem_wdata !== exp_wd)) begin
          fails++;
          $display("FAIL %s fields: we=%b addr=%h be=%b wd=%h, want we=%b addr=%h be=%b wd=%h",
                   name, dmem_we, dmem_addr, dmem_be, dmem_wdata, st, {a[31:2], 2'b00},
                   exp_be32[3:0], exp_wd);
        end
        dmem_ack = reqc == delay;
        reqc++;
      end else dmem_ack = 0;
      if (stall) stallc++;
      if (ld_valid) begin vldc++; got_ld = ld_data; end
      if (err) errc++;
      if (!stall && n > 0) begin fin = 1; mem_rden = 0; mem_wren = 0; end
      @(negedge clk); #1; n++;
    end
    dmem_ack = 0;
    tests++;
    if (!fin) begin fails++; $display("FAIL %s completion: stall still %b after %0d cycles, want 0", name, stall, n); end
    tests++;
    if (reqc !== exp_req) begin fails++; $display("FAIL %s req_cycles: got %0d want %0d", name, reqc, exp_req); end
    tests++;
    if (stallc !== (exp_err && exp_req == 0 ? 1 : exp_req + 1)) begin
      fails++; $display("FAIL %s stall_cycles: got %0d want %0d", name, stallc, exp_err && exp_req == 0 ? 1 : exp_req + 1);
    end
    tests++;
    if (errc !== exp_err) begin fails++; $display("FAIL %s err_pulses: got %0d want %0d", name, errc, exp_err); end
    tests++;
    if (vldc !== (!st && !exp_err ? 1 : 0)) begin fails++; $display("FAIL %s ld_valid_pulses: got %0d want %0d", name, vldc, !st && !exp_err); end
    if (!st && !exp_err) begin
      last_ld = exp_ld;
      tests++;
      if (got_ld !== exp_ld) begin fails++; $display("FAIL %s ld_data: got %h want %h", name, got_ld, exp_ld); end
    end
    tests++;
    if (ld_data !== last_ld || ld_valid !== 0 || err !== 0 || stall !== 0 || dmem_req !== 0) begin
      fails++;
      $display("FAIL %s after: ld_data=%h vld=%b err=%b stall=%b req=%b, want %h 0 0 0 0",
               name, ld_data, ld_valid, err, stall, dmem_req, last_ld);
    end
  endtask

  task automatic test_reset();
    mem_rden = 1; l_sel = 3'd5; addr = 32'h100;
    #1;
    tests++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall, ld_data, ld_valid, err} !== '0) begin
      fails++; $display("FAIL reset outputs: req=%b stall=%b ld_data=%h err=%b, want all 0", dmem_req, stall, ld_data, err);
    end
    mem_rden = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_lw();
    access(0, 3'd5, 2'd0, 32'h100, 0, 32'hDEADBEEF, 0, "lw_0x100");
    access(0, 3'd5, 2'd0, 32'h204, 0, 32'h0BADF00D, 3, "lw_delay3");
  endtask

  task automatic test_lb_lbu();
    access(0, 3'd1, 2'd0, 32'h103, 0, 32'h80FF_0000, 0, "lb_0x103");
    access(0, 3'd3, 2'd0, 32'h103, 0, 32'h80FF_0000, 1, "lbu_0x103");
    access(0, 3'd2, 2'd0, 32'h102, 0, 32'h9234_0000, 0, "lh_0x102");
    access(0, 3'd4, 2'd0, 32'h102, 0, 32'h9234_0000, 0, "lhu_0x102");
  endtask

  task automatic test_sh();
    access(1, 3'd0, 2'd2, 32'h22, 32'h1234ABCD, 0, 0, "sh_0x22");
    access(1, 3'd0, 2'd1, 32'h41, 32'h000000A5, 0, 2, "sb_0x41");
    access(1, 3'd0, 2'd3, 32'h80, 32'hCAFEBABE, 0, 0, "sw_0x80");
  endtask

  task automatic test_errors();
    access(0, 3'd5, 2'd0, 32'h102, 0, 0, 0, "lw_misaligned");
    access(0, 3'd6, 2'd0, 32'h100, 0, 0, 0, "lsel_110");
    access(1, 3'd0, 2'd0, 32'h100, 0, 0, 0, "ssel_00");
    access(1, 3'd0, 2'd2, 32'h101, 0, 0, 0, "sh_misaligned");
  endtask

  task automatic test_timeout();
    access(0, 3'd5, 2'd0, 32'h300, 0, 32'h11111111, 99, "lw_timeout");
    dmem_ack = 1;
    repeat (2) begin
      @(negedge clk); #1;
      tests++;
      if (dmem_req !== 0 || ld_valid !== 0 || stall !== 0 || ld_data !== last_ld) begin
        fails++; $display("FAIL late_ack: req=%b vld=%b stall=%b ld=%h, want 0 0 0 %h", dmem_req, ld_valid, stall, ld_data, last_ld);
      end
    end
    dmem_ack = 0;
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    mem_rden = 1; l_sel = 3'd5; addr = 32'h500;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (dmem_req !== 1) begin fails++; $display("FAIL mid_req_setup: req=%b want 1", dmem_req); end
    rst_n = 0;
    #1;
    tests++;
    if (dmem_req !== 0 || stall !== 0 || ld_data !== 0) begin
      fails++; $display("FAIL async_reset: req=%b stall=%b ld=%h, want 0 0 0", dmem_req, stall, ld_data);
    end
    last_ld = 0;
    mem_rden = 0;
    @(negedge clk); rst_n = 1;
    access(0, 3'd5, 2'd0, 32'h100, 0, 32'h5A5A1234, 0, "lw_after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      bit st;
      logic [2:0] ls;
      logic [1:0] ss;
      int d;
      st = 1'($urandom_range(0, 1));
      ls = 3'($urandom_range(0, 7));
      ss = 2'($urandom_range(0, 3));
      d = $urandom_range(0, 19) == 0 ? 20 : $urandom_range(0, 3);
      access(st, ls, ss, $urandom, $urandom, $urandom, d, "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_errors();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
